// File: rtl/cpu65_pkg.sv
// cpu65_pkg: shared types and width helpers for the 65C02 bus arbiter.
//   arb_state_t : bus ownership FSM states
//   cnt_w(n)    : bits needed to hold values 0..n (min 1)
//   idx_w(n)    : bits needed to index n items (min 1)
package cpu65_pkg;

   typedef enum logic [1:0] {
      CPU_OWN = 2'd0,
      HALT    = 2'd1,
      DMA_OWN = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if: bus-sharing signals between the arbiter and the
// CPU / DMA requesters.
//   mlb      : CPU memory lock (active low, RMW in progress)
//   req      : per-requester level request
//   gnt      : one-hot grant
//   rdy/be   : CPU RDY and BE controls
//   dma_busy : arbiter is not in CPU_OWN
// master = the arbiter, slave = CPU/requester side.
interface cpu_bus_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic               mlb;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic               rdy;
   logic               be;
   logic               dma_busy;

   modport master (input mlb, req, output gnt, rdy, be, dma_busy);
   modport slave  (output mlb, req, input gnt, rdy, be, dma_busy);
endinterface

// File: rtl/cpu_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i    : request vector
//   ptr_i    : highest-priority index this round
//   winner_o : first set request at/after ptr_i, wrapping
//   valid_o  : any request set
module rr_pick
   import cpu65_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [idx_w(NUM_REQ)-1:0]   ptr_i,
   output logic [idx_w(NUM_REQ)-1:0]   winner_o,
   output logic                        valid_o
);
   localparam int PW = idx_w(NUM_REQ);

   logic [PW-1:0] idx;

   // Scan from the farthest offset down so the closest hit to ptr_i is
   // written last and wins.
   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr_i) + i) % NUM_REQ);
         if (req_i[idx]) begin
            winner_o = idx;
            valid_o  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares the 65C02 bus between the CPU and NUM_REQ DMA
// requesters. Stalls the CPU (rdy), floats it (be), grants one requester
// per tenure round-robin, caps tenure length and guarantees the CPU a
// window after each tenure. Never takes the bus during a locked RMW.
//   phi2 : system clock (rising edge)
//   resb : async active-low reset
//   bus  : master modport (mlb, req in; gnt, rdy, be, dma_busy out)
// All outputs are registered, decoded from the next state.
module cpu_bus_arbiter
   import cpu65_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int MAX_BURST = 16,
   parameter int CPU_MIN   = 4
) (
   input  logic              phi2,
   input  logic              resb,
   cpu_bus_arbiter_if.master bus
);
   localparam int PW = idx_w(NUM_REQ);
   localparam int BW = cnt_w(MAX_BURST);
   localparam int CW = cnt_w(CPU_MIN);

   arb_state_t         state_q, state_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]      owner_q, owner_d;
   logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
   logic [CW-1:0]      cpu_cnt_q, cpu_cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               rdy_q, rdy_d;
   logic               be_q, be_d;
   logic               busy_q, busy_d;

   logic [PW-1:0]      winner;
   logic               pick_vld;
   logic               cpu_ok;
   logic               cap_hit;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i    (bus.req),
      .ptr_i    (rr_ptr_q),
      .winner_o (winner),
      .valid_o  (pick_vld)
   );

   // cpu_cnt is loaded with CPU_MIN on entry to CPU_OWN; allowing the
   // takeover decision at 1 makes the CPU window exactly CPU_MIN cycles
   // (and at least the one cycle the RELEASE->CPU_OWN hop always gives).
   assign cpu_ok  = (cpu_cnt_q <= CW'(1));
   assign cap_hit = (MAX_BURST != 0) && (burst_cnt_q == BW'(MAX_BURST - 1));

   // State register
   always_ff @(posedge phi2 or negedge resb) begin
      if (!resb) begin
         state_q     <= CPU_OWN;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         cpu_cnt_q   <= '0;
         gnt_q       <= '0;
         rdy_q       <= 1'b1;
         be_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         cpu_cnt_q   <= cpu_cnt_d;
         gnt_q       <= gnt_d;
         rdy_q       <= rdy_d;
         be_q        <= be_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      cpu_cnt_d   = cpu_cnt_q;
      case (state_q)
         CPU_OWN: begin
            if (cpu_cnt_q != '0) cpu_cnt_d = cpu_cnt_q - CW'(1);
            // mlb low means a locked RMW: never stall mid-sequence.
            if (|bus.req && bus.mlb && cpu_ok) state_d = HALT;
         end
         HALT: begin
            if (pick_vld) begin
               state_d     = DMA_OWN;
               owner_d     = winner;
               burst_cnt_d = '0;
               rr_ptr_d    = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);
            end else begin
               state_d = CPU_OWN;   // request withdrawn during the halt cycle
            end
         end
         DMA_OWN: begin
            burst_cnt_d = burst_cnt_q + BW'(1);
            if (!bus.req[owner_q] || cap_hit) state_d = RELEASE;
         end
         RELEASE: begin
            state_d   = CPU_OWN;
            cpu_cnt_d = CW'(CPU_MIN);
         end
         default: state_d = CPU_OWN;
      endcase
   end

   // Output decode of the next state, registered above
   always_comb begin
      gnt_d  = '0;
      rdy_d  = 1'b0;
      be_d   = 1'b0;
      busy_d = 1'b1;
      case (state_d)
         CPU_OWN: begin
            rdy_d  = 1'b1;
            be_d   = 1'b1;
            busy_d = 1'b0;
         end
         HALT:    be_d = 1'b1;          // CPU frozen but still driving
         DMA_OWN: gnt_d[owner_d] = 1'b1;
         default: ;                     // RELEASE: bus turnaround, nobody drives
      endcase
   end

   assign bus.gnt      = gnt_q;
   assign bus.rdy      = rdy_q;
   assign bus.be       = be_q;
   assign bus.dma_busy = busy_q;
endmodule
